instruction_loader: RTL

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader_pkg.sv | 16 +
 rtl/instruction_loader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the byte-stream instruction loader: FSM states and word geometry.
package instruction_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    BYTE,
    WRITE,
    DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_DEPTH  = 8192;

endpackage

// File: rtl/instruction_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory, one 32-bit word per write.
// Throughput is 5 cycles per word with continuous rx_valid; rx_ready drops during WRITE, DONE and IDLE.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [WIDTH-1:0] mem_addr,
  output logic [31:0]      mem_data,
  output logic             mem_wren,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int BW = $clog2(BYTES_PER_WORD);
  localparam int CW = ((WIDTH > 16) ? WIDTH : 16) + 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES_PER_WORD - 1);

  state_t          state, state_nxt;
  logic [15:0]     length;
  logic [WIDTH-1:0] word_idx;
  logic [BW-1:0]   byte_idx;
  logic [31:0]     word_buf, word_nxt;
  logic [15:0]     len_full;
  logic [CW-1:0]   idx_next;
  logic            accept, len_zero, len_over, last_word;

  assign accept    = rx_valid && rx_ready;
  assign len_full  = {rx_data, length[7:0]};
  assign len_zero  = (len_full == 16'd0);
  assign len_over  = (CW'(len_full) > CW'(DEPTH));
  assign idx_next  = CW'(word_idx) + CW'(1);
  assign last_word = (idx_next == CW'(length));

  always_comb begin
    word_nxt = word_buf;
    word_nxt[{byte_idx, 3'b000} +: 8] = rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    mem_wren  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        // Zero-length and oversize loads both finish without touching memory.
        if (rx_valid) state_nxt = (len_zero || len_over) ? DONE : BYTE;
      end
      BYTE: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_idx == LAST_BYTE) state_nxt = WRITE;
      end
      WRITE: begin
        mem_wren  = 1'b1;
        state_nxt = last_word ? DONE : BYTE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      length   <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_buf <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          err      <= 1'b0;
          word_idx <= '0;
          byte_idx <= '0;
        end
        LEN_LO: if (accept) length[7:0] <= rx_data;
        LEN_HI: if (accept) begin
          length[15:8] <= rx_data;
          if (len_over) err <= 1'b1;
        end
        BYTE: if (accept) begin
          word_buf <= word_nxt;
          byte_idx <= byte_idx + BW'(1);
          // Address/data are staged here so they are valid for the whole WRITE cycle.
          if (byte_idx == LAST_BYTE) begin
            mem_addr <= word_idx;
            mem_data <= word_nxt;
          end
        end
        WRITE: if (!last_word) word_idx <= word_idx + WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule
